issue_queue: RTL and testbench

Parametrised out-of-order issue queue for the ALU port of the backend, replacing the single-entry reservation-station path between rename/dispatch and PRF read. It holds up to DEPTH renamed micro-ops and tracks per-source readiness via NUM_CDB common-data-bus tag broadcasts. Each cycle it offers the oldest fully-ready entry to the execute stage through a valid/ready handshake. It also supports a whole-queue flush for mispredict recovery.

---
 rtl/issue_queue.sv | 149 ++++++++++++++
 tb/tb_issue_queue.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue.sv
// Out-of-order issue queue for the ALU port: holds renamed micro-ops, wakes sources
// from CDB broadcasts and offers the oldest fully-ready entry to execute.
module issue_queue #(
  parameter int DEPTH     = 8,
  parameter int TAG_W     = 6,
  parameter int PAYLOAD_W = 64,
  parameter int NUM_CDB   = 2,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [TAG_W-1:0]         disp_p_dest,
  input  logic [TAG_W-1:0]         disp_p_src1,
  input  logic [TAG_W-1:0]         disp_p_src2,
  input  logic                     disp_src1_ready,
  input  logic                     disp_src2_ready,
  input  logic [PAYLOAD_W-1:0]     disp_payload,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output logic [TAG_W-1:0]         issue_p_dest,
  output logic [TAG_W-1:0]         issue_p_src1,
  output logic [TAG_W-1:0]         issue_p_src2,
  output logic [PAYLOAD_W-1:0]     issue_payload,
  output logic [CNT_W-1:0]         count
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [DEPTH-1:0]     src1_rdy_q, src1_rdy_d;
  logic [DEPTH-1:0]     src2_rdy_q, src2_rdy_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [TAG_W-1:0]     dest_q [DEPTH];
  logic [TAG_W-1:0]     src1_q [DEPTH];
  logic [TAG_W-1:0]     src2_q [DEPTH];
  logic [PAYLOAD_W-1:0] payload_q [DEPTH];
  // older_q[i][j] set means entry j was dispatched before entry i.
  logic [DEPTH-1:0]     older_q [DEPTH];

  logic [DEPTH-1:0] eligible, sel_oh, wake1, wake2;
  logic [IDX_W-1:0] sel_idx, free_idx;
  logic             disp_fire, issue_fire;
  logic             disp_hit1, disp_hit2;

  function automatic logic cdb_match(input logic [TAG_W-1:0]         tag,
                                     input logic [NUM_CDB-1:0]       vld,
                                     input logic [NUM_CDB*TAG_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (vld[k] && (tags[k*TAG_W +: TAG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  assign disp_ready = (count_q < CNT_W'(DEPTH));
  assign count      = count_q;
  assign eligible   = valid_q & src1_rdy_q & src2_rdy_q;
  assign issue_valid = |eligible;
  assign disp_fire  = disp_valid && disp_ready && !flush && !reset;
  assign issue_fire = issue_valid && issue_ready && !flush && !reset;
  assign disp_hit1  = cdb_match(disp_p_src1, cdb_valid, cdb_tag);
  assign disp_hit2  = cdb_match(disp_p_src2, cdb_valid, cdb_tag);

  // An entry wins select when no other eligible entry is older than it.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel_oh[i] = eligible[i] && ~|(older_q[i] & eligible);
      wake1[i]  = cdb_match(src1_q[i], cdb_valid, cdb_tag);
      wake2[i]  = cdb_match(src2_q[i], cdb_valid, cdb_tag);
      if (sel_oh[i]) sel_idx = IDX_W'(i);
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    issue_p_dest  = '0;
    issue_p_src1  = '0;
    issue_p_src2  = '0;
    issue_payload = '0;
    if (issue_valid) begin
      issue_p_dest  = dest_q[sel_idx];
      issue_p_src1  = src1_q[sel_idx];
      issue_p_src2  = src2_q[sel_idx];
      issue_payload = payload_q[sel_idx];
    end
  end

  // NOTE: every signal assigned in this always_comb receives a default first,
  // so no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    valid_d    = valid_q;
    src1_rdy_d = src1_rdy_q | wake1;
    src2_rdy_d = src2_rdy_q | wake2;
    count_d    = count_q + CNT_W'(disp_fire) - CNT_W'(issue_fire);
    if (issue_fire) valid_d[sel_idx] = 1'b0;
    if (disp_fire) begin
      valid_d[free_idx]    = 1'b1;
      src1_rdy_d[free_idx] = disp_src1_ready || disp_hit1;
      src2_rdy_d[free_idx] = disp_src2_ready || disp_hit2;
    end
    if (flush) begin
      valid_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= '0;
      src1_rdy_q <= '0;
      src2_rdy_q <= '0;
      count_q    <= '0;
    end else begin
      valid_q    <= valid_d;
      src1_rdy_q <= src1_rdy_d;
      src2_rdy_q <= src2_rdy_d;
      count_q    <= count_d;
    end
  end

  // NOTE: entry storage and age bits are not reset; they are only observed
  // through an entry whose valid bit is set, and that is always written first.
  always_ff @(posedge clk) begin
    if (disp_fire) begin
      dest_q[free_idx]    <= disp_p_dest;
      src1_q[free_idx]    <= disp_p_src1;
      src2_q[free_idx]    <= disp_p_src2;
      payload_q[free_idx] <= disp_payload;
      for (int i = 0; i < DEPTH; i++) begin
        if (IDX_W'(i) == free_idx) older_q[i] <= valid_q;
        else                       older_q[i][free_idx] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed scenarios plus a randomized run
// compared against an in-order list model of the queue.
module tb_issue_queue;

  localparam int DEPTH = 8;
  localparam int TAG_W = 6;
  localparam int PW    = 64;
  localparam int NCDB  = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            reset, flush, disp_valid, disp_ready;
  logic [TAG_W-1:0] disp_p_dest, disp_p_src1, disp_p_src2;
  logic            disp_src1_ready, disp_src2_ready;
  logic [PW-1:0]   disp_payload;
  logic [NCDB-1:0] cdb_valid;
  logic [NCDB*TAG_W-1:0] cdb_tag;
  logic            issue_valid, issue_ready;
  logic [TAG_W-1:0] issue_p_dest, issue_p_src1, issue_p_src2;
  logic [PW-1:0]   issue_payload;
  logic [CW-1:0]   count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [TAG_W-1:0] dest, s1, s2;
    bit               r1, r2;
    logic [PW-1:0]    pl;
  } ent_t;

  issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PAYLOAD_W(PW), .NUM_CDB(NCDB)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_p_dest(disp_p_dest), .disp_p_src1(disp_p_src1), .disp_p_src2(disp_p_src2),
    .disp_src1_ready(disp_src1_ready), .disp_src2_ready(disp_src2_ready),
    .disp_payload(disp_payload), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_p_dest(issue_p_dest), .issue_p_src1(issue_p_src1), .issue_p_src2(issue_p_src2),
    .issue_payload(issue_payload), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 1'b0; flush = 1'b0; disp_valid = 1'b0;
    disp_p_dest = '0; disp_p_src1 = '0; disp_p_src2 = '0;
    disp_src1_ready = 1'b0; disp_src2_ready = 1'b0; disp_payload = '0;
    cdb_valid = '0; cdb_tag = '0; issue_ready = 1'b0;
  endtask

  task automatic set_disp(input int dest, input int s1, input int s2,
                          input bit r1, input bit r2, input logic [PW-1:0] pl);
    disp_valid = 1'b1;
    disp_p_dest = TAG_W'(dest); disp_p_src1 = TAG_W'(s1); disp_p_src2 = TAG_W'(s2);
    disp_src1_ready = r1; disp_src2_ready = r2; disp_payload = pl;
  endtask

  function automatic bit hit(input logic [TAG_W-1:0] t, input logic [NCDB-1:0] v,
                             input logic [NCDB*TAG_W-1:0] tags);
    for (int k = 0; k < NCDB; k++)
      if (v[k] && tags[k*TAG_W +: TAG_W] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic test_reset();
    idle();
    reset = 1'b1;
    set_disp(9, 1, 2, 1, 1, 64'h55);
    tick(); tick();
    idle();
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_issue_valid got %0b want 0", issue_valid); end
    n_checks++; if (issue_p_dest !== '0) begin n_fail++; $display("FAIL reset_issue_dest got %0d want 0", issue_p_dest); end
    n_checks++; if (issue_payload !== '0) begin n_fail++; $display("FAIL reset_issue_payload got %0h want 0", issue_payload); end
    n_checks++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_disp_ready got %0b want 1", disp_ready); end
    n_checks++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
  endtask

  task automatic test_basic();
    set_disp(3, 1, 2, 1, 1, 64'hABCD);
    tick();
    idle();
    n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %0b want 1", issue_valid); end
    n_checks++; if (issue_p_dest !== 6'd3) begin n_fail++; $display("FAIL basic_dest got %0d want 3", issue_p_dest); end
    n_checks++; if (issue_payload !== 64'hABCD) begin n_fail++; $display("FAIL basic_payload got %0h want abcd", issue_payload); end
    n_checks++; if (issue_p_src1 !== 6'd1 || issue_p_src2 !== 6'd2) begin n_fail++; $display("FAIL basic_srcs got %0d/%0d want 1/2", issue_p_src1, issue_p_src2); end
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL basic_count1 got %0d want 1", count); end
    issue_ready = 1'b1;
    tick();
    idle();
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL basic_count0 got %0d want 0", count); end
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL basic_empty got %0b want 0", issue_valid); end
  endtask

  task automatic test_wakeup();
    set_disp(3, 1, 2, 1, 1, 64'hA);
    tick();
    set_disp(4, 3, 2, 0, 1, 64'hB);
    tick();
    idle();
    n_checks++; if (issue_p_dest !== 6'd3) begin n_fail++; $display("FAIL wake_first got %0d want 3", issue_p_dest); end
    issue_ready = 1'b1;
    tick();
    idle();
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL wake_blocked got %0b want 0", issue_valid); end
    cdb_valid = 2'b10; cdb_tag = {6'd3, 6'd0};
    tick();
    idle();
    n_checks++; if (issue_valid !== 1'b1 || issue_p_dest !== 6'd4) begin n_fail++; $display("FAIL wake_offer got v=%0b d=%0d want v=1 d=4", issue_valid, issue_p_dest); end
    issue_ready = 1'b1;
    tick();
    idle();
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL wake_count got %0d want 0", count); end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      set_disp(10 + i, 1, 2, 1, 1, 64'(i));
      tick();
    end
    idle();
    n_checks++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %0b want 0", disp_ready); end
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_count got %0d want 8", count); end
    set_disp(50, 1, 2, 1, 1, 64'h50);
    issue_ready = 1'b1;
    tick();
    idle();
    n_checks++; if (count !== 4'd7) begin n_fail++; $display("FAIL full_issue_count got %0d want 7", count); end
    n_checks++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after got %0b want 1", disp_ready); end
    for (int i = 1; i < DEPTH; i++) begin
      n_checks++;
      if (issue_valid !== 1'b1 || issue_p_dest !== TAG_W'(10 + i)) begin
        n_fail++; $display("FAIL full_drain got v=%0b d=%0d want v=1 d=%0d", issue_valid, issue_p_dest, 10 + i);
      end
      issue_ready = 1'b1;
      tick();
    end
    idle();
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL full_drained got %0d want 0", count); end
  endtask

  task automatic test_order();
    set_disp(20, 5, 2, 0, 1, 64'hC); tick();
    set_disp(21, 1, 2, 1, 1, 64'hD); tick();
    set_disp(22, 1, 2, 1, 1, 64'hE); tick();
    idle();
    n_checks++; if (issue_p_dest !== 6'd21) begin n_fail++; $display("FAIL order_d got %0d want 21", issue_p_dest); end
    issue_ready = 1'b1; tick(); idle();
    n_checks++; if (issue_p_dest !== 6'd22) begin n_fail++; $display("FAIL order_e got %0d want 22", issue_p_dest); end
    issue_ready = 1'b1; tick(); idle();
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL order_c_wait got %0b want 0", issue_valid); end
    cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd5}; tick(); idle();
    n_checks++; if (issue_p_dest !== 6'd20) begin n_fail++; $display("FAIL order_c got %0d want 20", issue_p_dest); end
    issue_ready = 1'b1; tick(); idle();
    set_disp(23, 1, 9, 1, 0, 64'h23); tick();
    set_disp(24, 1, 2, 1, 1, 64'h24); tick();
    set_disp(25, 1, 2, 1, 1, 64'h25); tick();
    idle();
    n_checks++; if (issue_p_dest !== 6'd24) begin n_fail++; $display("FAIL order_d2 got %0d want 24", issue_p_dest); end
    cdb_valid = 2'b10; cdb_tag = {6'd9, 6'd0}; tick(); idle();
    for (int i = 23; i <= 25; i++) begin
      n_checks++;
      if (issue_valid !== 1'b1 || issue_p_dest !== TAG_W'(i)) begin
        n_fail++; $display("FAIL order_oldest got v=%0b d=%0d want v=1 d=%0d", issue_valid, issue_p_dest, i);
      end
      issue_ready = 1'b1; tick(); idle();
    end
  endtask

  task automatic test_bypass();
    set_disp(30, 7, 2, 0, 1, 64'h30);
    cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd7};
    tick(); idle();
    n_checks++; if (issue_valid !== 1'b1 || issue_p_dest !== 6'd30) begin n_fail++; $display("FAIL bypass1 got v=%0b d=%0d want v=1 d=30", issue_valid, issue_p_dest); end
    issue_ready = 1'b1; tick(); idle();
    set_disp(31, 1, 8, 1, 0, 64'h31);
    cdb_valid = 2'b10; cdb_tag = {6'd8, 6'd0};
    tick(); idle();
    n_checks++; if (issue_valid !== 1'b1 || issue_p_dest !== 6'd31) begin n_fail++; $display("FAIL bypass2 got v=%0b d=%0d want v=1 d=31", issue_valid, issue_p_dest); end
    issue_ready = 1'b1; tick(); idle();
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL bypass_count got %0d want 0", count); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      set_disp(40 + i, 1, 2, 1, 1, 64'(i)); tick();
    end
    idle();
    n_checks++; if (count !== 4'd5) begin n_fail++; $display("FAIL flush_fill got %0d want 5", count); end
    set_disp(45, 1, 2, 1, 1, 64'h45);
    flush = 1'b1; issue_ready = 1'b1;
    tick(); idle();
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL flush_count got %0d want 0", count); end
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %0b want 0", issue_valid); end
    tick();
    n_checks++; if (count !== 4'd0 || issue_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped got c=%0d v=%0b want c=0 v=0", count, issue_valid); end
  endtask

  task automatic test_random();
    ent_t mq[$];
    ent_t e;
    int   sel;
    bit   dfire;
    idle();
    flush = 1'b1; tick(); idle();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      sel = -1;
      foreach (mq[j]) if (sel < 0 && mq[j].r1 && mq[j].r2) sel = j;
      n_checks++;
      if (issue_valid !== (sel >= 0)) begin n_fail++; $display("FAIL rand_valid cyc %0d got %0b want %0b", cyc, issue_valid, sel >= 0); end
      if (sel >= 0) begin
        n_checks++;
        if (issue_p_dest !== mq[sel].dest || issue_p_src1 !== mq[sel].s1 ||
            issue_p_src2 !== mq[sel].s2 || issue_payload !== mq[sel].pl) begin
          n_fail++; $display("FAIL rand_entry cyc %0d got d=%0d pl=%0h want d=%0d pl=%0h", cyc, issue_p_dest, issue_payload, mq[sel].dest, mq[sel].pl);
        end
      end else begin
        n_checks++;
        if (issue_p_dest !== '0 || issue_payload !== '0) begin n_fail++; $display("FAIL rand_zero cyc %0d got d=%0d pl=%0h want 0", cyc, issue_p_dest, issue_payload); end
      end
      n_checks++;
      if (count !== CW'(mq.size()) || disp_ready !== (mq.size() < DEPTH)) begin
        n_fail++; $display("FAIL rand_count cyc %0d got c=%0d r=%0b want c=%0d", cyc, count, disp_ready, mq.size());
      end
      disp_valid      = ($urandom_range(0, 99) < 60);
      disp_p_dest     = TAG_W'($urandom_range(0, 63));
      disp_p_src1     = TAG_W'($urandom_range(0, 15));
      disp_p_src2     = TAG_W'($urandom_range(0, 15));
      disp_src1_ready = ($urandom_range(0, 2) == 0);
      disp_src2_ready = ($urandom_range(0, 2) == 0);
      disp_payload    = {$urandom, $urandom};
      cdb_valid       = NCDB'($urandom_range(0, 3));
      cdb_tag         = {TAG_W'($urandom_range(0, 15)), TAG_W'($urandom_range(0, 15))};
      issue_ready     = ($urandom_range(0, 99) < 70);
      flush           = ($urandom_range(0, 99) == 0);
      if (flush) mq.delete();
      else begin
        dfire = disp_valid && (mq.size() < DEPTH);
        if (sel >= 0 && issue_ready) mq.delete(sel);
        foreach (mq[j]) begin
          if (hit(mq[j].s1, cdb_valid, cdb_tag)) mq[j].r1 = 1'b1;
          if (hit(mq[j].s2, cdb_valid, cdb_tag)) mq[j].r2 = 1'b1;
        end
        if (dfire) begin
          e.dest = disp_p_dest; e.s1 = disp_p_src1; e.s2 = disp_p_src2; e.pl = disp_payload;
          e.r1 = disp_src1_ready || hit(disp_p_src1, cdb_valid, cdb_tag);
          e.r2 = disp_src2_ready || hit(disp_p_src2, cdb_valid, cdb_tag);
          mq.push_back(e);
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_full();
    test_order();
    test_bypass();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
